// File: rtl/canny_pkg.sv
// Constants shared by the window producer and all window consumers of the canny pipeline.
package canny_pkg;
  localparam int DW_DEFAULT    = 16;
  localparam int IMG_W_DEFAULT = 640;
  localparam int IMG_H_DEFAULT = 480;

  // data_valid polarity seen by consumers: high marks a border (unusable) window
  localparam logic WIN_INVALID = 1'b1;
  localparam logic WIN_USABLE  = ~WIN_INVALID;
endpackage

// File: rtl/line_buffer2.sv
// Two chained line memories: tap1 is the previous line, tap2 the line before that.
module line_buffer2 #(
  parameter int DW    = 16,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] tap1,
  output logic [DW-1:0] tap2
);
  logic [DW-1:0] lb1 [DEPTH];
  logic [DW-1:0] lb2 [DEPTH];

  // Asynchronous read so the current column's history is available in the accept cycle
  assign tap1 = lb1[addr];
  assign tap2 = lb2[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      lb2[addr] <= lb1[addr];
      lb1[addr] <= din;
    end
  end
endmodule

// File: rtl/matrix3x3_gen.sv
// Raster-to-3x3 window generator: line buffers, column/row tracking and border flagging.
module matrix3x3_gen
  import canny_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          matrix_clken,
  output logic          data_valid,
  output logic [DW-1:0] matrix_p11,
  output logic [DW-1:0] matrix_p12,
  output logic [DW-1:0] matrix_p13,
  output logic [DW-1:0] matrix_p21,
  output logic [DW-1:0] matrix_p22,
  output logic [DW-1:0] matrix_p23,
  output logic [DW-1:0] matrix_p31,
  output logic [DW-1:0] matrix_p32,
  output logic [DW-1:0] matrix_p33,
  output logic          frame_done,
  output logic          ready
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] tap1, tap2;
  logic          accept, last_col, last_row, border;

  assign ready    = start;
  assign accept   = start && pix_valid;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign border   = (row < RW'(2)) || (col < CW'(2));

  line_buffer2 #(.DW(DW), .DEPTH(IMG_W), .AW(CW)) u_lb (
    .clk  (clk),
    .we   (accept),
    .addr (col),
    .din  (pix_data),
    .tap1 (tap1),
    .tap2 (tap2)
  );

  // Dropping start rewinds to (0,0); an accept in the same cycle cannot occur since accept needs start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (!start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matrix_clken <= 1'b0;
      frame_done   <= 1'b0;
      data_valid   <= WIN_INVALID;
      matrix_p11   <= '0;
      matrix_p12   <= '0;
      matrix_p13   <= '0;
      matrix_p21   <= '0;
      matrix_p22   <= '0;
      matrix_p23   <= '0;
      matrix_p31   <= '0;
      matrix_p32   <= '0;
      matrix_p33   <= '0;
    end else begin
      matrix_clken <= accept;
      frame_done   <= accept && last_col && last_row;
      if (accept) begin
        data_valid <= border ? WIN_INVALID : WIN_USABLE;
        matrix_p11 <= matrix_p12;
        matrix_p12 <= matrix_p13;
        matrix_p13 <= tap2;
        matrix_p21 <= matrix_p22;
        matrix_p22 <= matrix_p23;
        matrix_p23 <= tap1;
        matrix_p31 <= matrix_p32;
        matrix_p32 <= matrix_p33;
        matrix_p33 <= pix_data;
      end
    end
  end
endmodule

// File: tb/tb_matrix3x3_gen.sv
// Scoreboard bench for matrix3x3_gen on a 5x4 image with pixel value off + 16*row + col.
module tb_matrix3x3_gen;
  localparam int DW = 16;
  localparam int W  = 5;
  localparam int H  = 4;

  logic          clk, rst, start, pix_valid;
  logic [DW-1:0] pix_data;
  logic          matrix_clken, data_valid, frame_done, ready;
  logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;

  matrix3x3_gen #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .matrix_clken (matrix_clken),
    .data_valid   (data_valid),
    .matrix_p11   (matrix_p11),
    .matrix_p12   (matrix_p12),
    .matrix_p13   (matrix_p13),
    .matrix_p21   (matrix_p21),
    .matrix_p22   (matrix_p22),
    .matrix_p23   (matrix_p23),
    .matrix_p31   (matrix_p31),
    .matrix_p32   (matrix_p32),
    .matrix_p33   (matrix_p33),
    .frame_done   (frame_done),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            r;
    int            c;
    logic [DW-1:0] off;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  bit            acc_pending = 1'b0;
  logic [DW-1:0] last_p33 = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  // Whether an accept happened at the most recent edge (inputs change 1 time unit after edges)
  always @(posedge clk or posedge rst) begin
    if (rst) acc_pending = 1'b0;
    else     acc_pending = start && pix_valid;
  end

  // Monitor: pops one expected window per matrix_clken pulse
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", {31'd0, ready}, {31'd0, start});
      chk("clken_timing", {31'd0, matrix_clken}, {31'd0, acc_pending});
      if (matrix_clken) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_clken: got window with empty scoreboard, required none");
        end else begin
          exp_t e;
          logic [DW-1:0] act [9];
          e = sb.pop_front();
          act = '{matrix_p11, matrix_p12, matrix_p13,
                  matrix_p21, matrix_p22, matrix_p23,
                  matrix_p31, matrix_p32, matrix_p33};
          for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
              int rr, cc;
              rr = e.r - 2 + i;
              cc = e.c - 2 + j;
              if (rr >= 0 && cc >= 0)
                chk($sformatf("p%0d%0d@r%0dc%0d", i + 1, j + 1, e.r, e.c),
                    {16'd0, act[i*3+j]}, {16'd0, e.off + DW'(16 * rr + cc)});
            end
          end
          chk($sformatf("data_valid@r%0dc%0d", e.r, e.c), {31'd0, data_valid},
              {31'd0, (e.r < 2 || e.c < 2)});
          chk($sformatf("frame_done@r%0dc%0d", e.r, e.c), {31'd0, frame_done},
              {31'd0, (e.r == H - 1 && e.c == W - 1)});
          last_p33 = e.off + DW'(16 * e.r + e.c);
          $display("win r=%0d c=%0d off=0x%0h p22=0x%0h p33=0x%0h dv=%0b fd=%0b",
                   e.r, e.c, e.off, matrix_p22, matrix_p33, data_valid, frame_done);
        end
      end else begin
        chk("hold_p33", {16'd0, matrix_p33}, {16'd0, last_p33});
        chk("frame_done_idle", {31'd0, frame_done}, 32'd0);
      end
    end
  end

  task automatic send(input int r, input int c, input logic [DW-1:0] off);
    start     = 1'b1;
    pix_valid = 1'b1;
    pix_data  = off + DW'(16 * r + c);
    sb.push_back('{r: r, c: c, off: off});
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_data  = 16'hdead;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_data  = 16'hbeef;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] off, input int gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r, c, off);
        if (gap > 0) idle(gap);
      end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_clken"}, {31'd0, matrix_clken}, 32'd0);
    chk({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_dv"}, {31'd0, data_valid}, 32'd1);
    chk({tag, "_win"}, {matrix_p11 | matrix_p12 | matrix_p13 | matrix_p21 | matrix_p22,
                        matrix_p23 | matrix_p31 | matrix_p32 | matrix_p33}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    #2;
    check_cleared("reset");
    chk("reset_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Continuous frame, including border and full-window cases
    send_frame(16'h0000, 0);
    // pix_valid 1,0,0,1 pattern
    send_frame(16'h0000, 2);
    // Back-to-back frames, second offset by 0x80
    send_frame(16'h0000, 0);
    send_frame(16'h0080, 0);

    // Drop start after pixel (1,3), then restart at (0,0)
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r * W + c <= W + 3) send(r, c, 16'h0000);
    start = 1'b0;
    idle(3);
    chk("ready_low", {31'd0, ready}, 32'd0);
    send_frame(16'h0040, 0);
    // start falls right after the last-pixel accept
    start = 1'b0;
    idle(2);

    // Asynchronous reset mid-frame, between edges
    start = 1'b1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r * W + c <= 2 * W + 1) send(r, c, 16'h0000);
    #1;
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    sb.delete();
    last_p33 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(16'h0000, 0);
    idle(3);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
